multicycle_ctrl: RTL and testbench

- Multicycle control FSM for the 8-bit MIPS-subset datapath. It replaces the single-cycle combinational control unit.
- It sequences one instruction over 3-5 steps: Fetch, Decode, Execute, Memory, Writeback. One shared ALU and one unified memory serve all steps.
- A step-enable input lets a debounced push-button advance the machine one state at a time on the board.
- It also drives a state code and a retired-instruction counter for LED/LCD debug display.

---
 rtl/mc_pkg.sv | 52 +++++
 rtl/multicycle_ctrl_if.sv | 37 +++
 rtl/multicycle_ctrl_alu_decoder.sv | 33 +++
 rtl/multicycle_ctrl.sv | 145 ++++++++++++++
 tb/tb_multicycle_ctrl.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS-subset controller: states, opcodes,
// Funct codes, ALU operation codes and datapath mux select codes.
package mc_pkg;

  typedef enum logic [3:0] {
    S_RESET  = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_JUMP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ULA_AND = 3'b000;
  localparam logic [2:0] ULA_OR  = 3'b001;
  localparam logic [2:0] ULA_ADD = 3'b010;
  localparam logic [2:0] ULA_SUB = 3'b110;
  localparam logic [2:0] ULA_SLT = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RD2 = 2'b00;
  localparam logic [1:0] SRCB_ONE = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;

  localparam logic [1:0] PCSRC_ULA    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle: instruction fields and flags in, strobes,
// mux selects and debug outputs back. master = controller side.
interface multicycle_ctrl_if #(parameter int CNT_W = 8);

  logic             en;
  logic [5:0]       OP;
  logic [5:0]       Funct;
  logic             Zero;

  logic             PCEn;
  logic             IorD;
  logic             MemWrite;
  logic             IRWrite;
  logic             RegDst;
  logic             MemtoReg;
  logic             RegWrite;
  logic             ULASrcA;
  logic [1:0]       ULASrcB;
  logic [2:0]       ULAControl;
  logic [1:0]       PCSrc;
  logic [3:0]       State;
  logic             Illegal;
  logic [CNT_W-1:0] Retired;

  modport master (
    input  en, OP, Funct, Zero,
    output PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ULASrcA, ULASrcB, ULAControl, PCSrc, State, Illegal, Retired
  );

  modport slave (
    output en, OP, Funct, Zero,
    input  PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ULASrcA, ULASrcB, ULAControl, PCSrc, State, Illegal, Retired
  );

endinterface

// File: rtl/multicycle_ctrl_alu_decoder.sv
// ALU operation decoder: fixed add/sub for address and branch steps,
// Funct-driven operation for R-type execute.
module alu_decoder
  import mc_pkg::*;
(
  input  logic [1:0] ALUOp,
  input  logic [5:0] Funct,
  output logic [2:0] ULAControl,
  output logic       illegal_funct
);

  // NOTE: every output gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    ULAControl    = ULA_ADD;
    illegal_funct = 1'b0;
    case (ALUOp)
      ALUOP_SUB:   ULAControl = ULA_SUB;
      ALUOP_FUNCT: begin
        case (Funct)
          FN_ADD:  ULAControl = ULA_ADD;
          FN_SUB:  ULAControl = ULA_SUB;
          FN_AND:  ULAControl = ULA_AND;
          FN_OR:   ULAControl = ULA_OR;
          FN_SLT:  ULAControl = ULA_SLT;
          default: illegal_funct = 1'b1;
        endcase
      end
      default:     ULAControl = ULA_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for the 8-bit MIPS-subset datapath, with step enable
// for single-stepping on the board and a retired-instruction counter.
module multicycle_ctrl
  import mc_pkg::*;
#(
  parameter bit USE_EN = 1'b1,
  parameter int CNT_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  multicycle_ctrl_if.master  bus
);

  state_t           state_q, state_d, state_nxt;
  logic             step;
  logic             pc_write, branch, ir_write, reg_write, mem_write;
  logic             illegal_op, retire_from;
  logic [1:0]       alu_op;
  logic [2:0]       ula_ctrl;
  logic             illegal_funct;
  logic [CNT_W-1:0] retired_q;

  assign step = USE_EN ? bus.en : 1'b1;

  alu_decoder u_alu_decoder (
    .ALUOp        (alu_op),
    .Funct        (bus.Funct),
    .ULAControl   (ula_ctrl),
    .illegal_funct(illegal_funct)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value; the reset branch is asynchronous via the sensitivity list.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_RESET;
    else     state_q <= state_d;
  end

  always_comb begin
    state_nxt    = S_FETCH;
    pc_write     = 1'b0;
    branch       = 1'b0;
    ir_write     = 1'b0;
    reg_write    = 1'b0;
    mem_write    = 1'b0;
    illegal_op   = 1'b0;
    retire_from  = 1'b0;
    bus.IorD     = 1'b0;
    bus.RegDst   = 1'b0;
    bus.MemtoReg = 1'b0;
    bus.ULASrcA  = 1'b0;
    bus.ULASrcB  = SRCB_RD2;
    bus.PCSrc    = PCSRC_ULA;
    alu_op       = ALUOP_ADD;
    case (state_q)
      S_RESET:  state_nxt = S_FETCH;
      S_FETCH: begin
        ir_write    = 1'b1;
        pc_write    = 1'b1;
        bus.ULASrcB = SRCB_ONE;
        state_nxt   = S_DECODE;
      end
      S_DECODE: begin
        bus.ULASrcB = SRCB_IMM;
        case (bus.OP)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_RTYPE:     state_nxt = S_EXEC;
          OP_BEQ:       state_nxt = S_BRANCH;
          OP_ADDI:      state_nxt = S_ADDIEX;
          OP_J:         state_nxt = S_JUMP;
          default:      illegal_op = 1'b1;
        endcase
      end
      S_MEMADR: begin
        bus.ULASrcA = 1'b1;
        bus.ULASrcB = SRCB_IMM;
        state_nxt   = (bus.OP == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        bus.IorD  = 1'b1;
        state_nxt = S_MEMWB;
      end
      S_MEMWB: begin
        bus.MemtoReg = 1'b1;
        reg_write    = 1'b1;
        retire_from  = 1'b1;
      end
      S_MEMWR: begin
        bus.IorD    = 1'b1;
        mem_write   = 1'b1;
        retire_from = 1'b1;
      end
      S_EXEC: begin
        bus.ULASrcA = 1'b1;
        alu_op      = ALUOP_FUNCT;
        state_nxt   = S_ALUWB;
      end
      S_ALUWB: begin
        bus.RegDst  = 1'b1;
        reg_write   = 1'b1;
        retire_from = 1'b1;
      end
      S_BRANCH: begin
        bus.ULASrcA = 1'b1;
        bus.PCSrc   = PCSRC_ALUOUT;
        alu_op      = ALUOP_SUB;
        branch      = 1'b1;
        retire_from = 1'b1;
      end
      S_ADDIEX: begin
        bus.ULASrcA = 1'b1;
        bus.ULASrcB = SRCB_IMM;
        state_nxt   = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write   = 1'b1;
        retire_from = 1'b1;
      end
      S_JUMP: begin
        bus.PCSrc   = PCSRC_JUMP;
        pc_write    = 1'b1;
        retire_from = 1'b1;
      end
      default:  state_nxt = S_FETCH;
    endcase
    state_d = step ? state_nxt : state_q;
  end

  // Strobes commit only on an enabled step, giving one commit per button press.
  assign bus.PCEn       = step & (pc_write | (branch & bus.Zero));
  assign bus.IRWrite    = step & ir_write;
  assign bus.RegWrite   = step & reg_write;
  assign bus.MemWrite   = step & mem_write;
  assign bus.Illegal    = step & (illegal_op | ((state_q == S_EXEC) & illegal_funct));
  assign bus.ULAControl = (state_q == S_RESET) ? 3'b000 : ula_ctrl;
  assign bus.State      = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      retired_q <= '0;
    else if (step && retire_from) retired_q <= retired_q + 1'b1;
  end

  assign bus.Retired = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: directed instruction sequences push
// expected per-cycle outputs; a negedge monitor pops and compares.
module tb_multicycle_ctrl;
  import mc_pkg::*;

  localparam int CNT_W = 8;

  // Select vector layout: {IorD, RegDst, MemtoReg, ULASrcA, ULASrcB[1:0], ULAControl[2:0], PCSrc[1:0]}
  localparam logic [10:0] SEL_FETCH = 11'b0_0_0_0_01_010_00;
  localparam logic [10:0] M_FETCH   = 11'b1_0_0_1_11_111_11;
  localparam logic [10:0] SEL_DEC   = 11'b0_0_0_0_10_010_00;
  localparam logic [10:0] SEL_MADR  = 11'b0_0_0_1_10_010_00;
  localparam logic [10:0] M_ALU     = 11'b0_0_0_1_11_111_00;
  localparam logic [10:0] SEL_IORD  = 11'b1_0_0_0_00_000_00;
  localparam logic [10:0] M_IORD    = 11'b1_0_0_0_00_000_00;
  localparam logic [10:0] SEL_MEMWB = 11'b0_0_1_0_00_000_00;
  localparam logic [10:0] SEL_ALUWB = 11'b0_1_0_0_00_000_00;
  localparam logic [10:0] SEL_ZERO  = 11'b0_0_0_0_00_000_00;
  localparam logic [10:0] M_WB      = 11'b0_1_1_0_00_000_00;
  localparam logic [10:0] SEL_BR    = 11'b0_0_0_1_00_110_01;
  localparam logic [10:0] M_BR      = 11'b0_0_0_1_11_111_11;
  localparam logic [10:0] SEL_JUMP  = 11'b0_0_0_0_00_000_10;
  localparam logic [10:0] M_PC      = 11'b0_0_0_0_00_000_11;
  localparam logic [10:0] M_RST     = 11'b1_1_1_1_11_000_11;

  // Strobe vector layout: {PCEn, MemWrite, IRWrite, RegWrite, Illegal}
  localparam logic [4:0] ST_NONE  = 5'b00000;
  localparam logic [4:0] ST_FETCH = 5'b10100;
  localparam logic [4:0] ST_MEMWR = 5'b01000;
  localparam logic [4:0] ST_RW    = 5'b00010;
  localparam logic [4:0] ST_PC    = 5'b10000;
  localparam logic [4:0] ST_ILL   = 5'b00001;

  localparam logic [5:0] OP_BAD = 6'b111111;
  localparam logic [5:0] FN_BAD = 6'b111111;

  typedef struct {
    string            name;
    logic [3:0]       state;
    logic [4:0]       strb;
    logic [CNT_W-1:0] ret;
    logic [10:0]      sel;
    logic [10:0]      mask;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_ret = 0;

  always #5 clk = ~clk;

  multicycle_ctrl_if #(.CNT_W(CNT_W)) bus ();

  multicycle_ctrl #(.USE_EN(1'b1), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    logic [10:0] sel_act;
    if (q.size() > 0) begin
      e = q.pop_front();
      sel_act = {bus.IorD, bus.RegDst, bus.MemtoReg, bus.ULASrcA, bus.ULASrcB,
                 bus.ULAControl, bus.PCSrc};
      check({e.name, " State"}, 32'(bus.State), 32'(e.state));
      check({e.name, " strobes"},
            32'({bus.PCEn, bus.MemWrite, bus.IRWrite, bus.RegWrite, bus.Illegal}),
            32'(e.strb));
      check({e.name, " Retired"}, 32'(bus.Retired), 32'(e.ret));
      check({e.name, " selects"}, 32'(sel_act & e.mask), 32'(e.sel & e.mask));
    end
  end

  // Drive one cycle of inputs, queue what the DUT must show in that cycle.
  task automatic step(input string name, input logic en, input logic [5:0] op,
                      input logic [5:0] fn, input logic z, input state_t st,
                      input logic [4:0] strb, input logic [10:0] sel, input logic [10:0] mask);
    exp_t e;
    bus.en    = en;
    bus.OP    = op;
    bus.Funct = fn;
    bus.Zero  = z;
    e.name  = name;
    e.state = st;
    e.strb  = strb;
    e.ret   = exp_ret[CNT_W-1:0];
    e.sel   = sel;
    e.mask  = mask;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_dec(input string tag, input logic [5:0] op, input logic [5:0] fn,
                           input logic [4:0] dec_strb);
    step({tag, " fetch"},  1'b1, op, fn, 1'b0, S_FETCH,  ST_FETCH, SEL_FETCH, M_FETCH);
    step({tag, " decode"}, 1'b1, op, fn, 1'b0, S_DECODE, dec_strb, SEL_DEC,   M_ALU);
  endtask

  task automatic run_lw();
    fetch_dec("lw", OP_LW, 6'd0, ST_NONE);
    step("lw memadr", 1'b1, OP_LW, 6'd0, 1'b0, S_MEMADR, ST_NONE, SEL_MADR,  M_ALU);
    step("lw memrd",  1'b1, OP_LW, 6'd0, 1'b0, S_MEMRD,  ST_NONE, SEL_IORD,  M_IORD);
    step("lw memwb",  1'b1, OP_LW, 6'd0, 1'b0, S_MEMWB,  ST_RW,   SEL_MEMWB, M_WB);
    exp_ret++;
  endtask

  task automatic run_rtype(input string tag, input logic [5:0] fn, input logic [2:0] ulac,
                           input logic [4:0] exec_strb);
    fetch_dec(tag, OP_RTYPE, fn, ST_NONE);
    step({tag, " exec"},  1'b1, OP_RTYPE, fn, 1'b0, S_EXEC,  exec_strb,
         {4'b0001, 2'b00, ulac, 2'b00}, M_ALU);
    step({tag, " aluwb"}, 1'b1, OP_RTYPE, fn, 1'b0, S_ALUWB, ST_RW, SEL_ALUWB, M_WB);
    exp_ret++;
  endtask

  task automatic run_beq(input logic z);
    fetch_dec("beq", OP_BEQ, 6'd0, ST_NONE);
    step("beq branch", 1'b1, OP_BEQ, 6'd0, z, S_BRANCH, z ? ST_PC : ST_NONE, SEL_BR, M_BR);
    exp_ret++;
  endtask

  task automatic run_sw_hold();
    fetch_dec("sw", OP_SW, 6'd0, ST_NONE);
    step("sw memadr", 1'b1, OP_SW, 6'd0, 1'b0, S_MEMADR, ST_NONE, SEL_MADR, M_ALU);
    for (int i = 0; i < 5; i++)
      step("sw memwr hold", 1'b0, OP_SW, 6'd0, 1'b0, S_MEMWR, ST_NONE, SEL_IORD, M_IORD);
    step("sw memwr", 1'b1, OP_SW, 6'd0, 1'b0, S_MEMWR, ST_MEMWR, SEL_IORD, M_IORD);
    exp_ret++;
  endtask

  task automatic run_addi();
    fetch_dec("addi", OP_ADDI, 6'd0, ST_NONE);
    step("addi ex", 1'b1, OP_ADDI, 6'd0, 1'b0, S_ADDIEX, ST_NONE, SEL_MADR, M_ALU);
    step("addi wb", 1'b1, OP_ADDI, 6'd0, 1'b0, S_ADDIWB, ST_RW,   SEL_ZERO, M_WB);
    exp_ret++;
  endtask

  task automatic run_j();
    fetch_dec("j", OP_J, 6'd0, ST_NONE);
    step("j jump", 1'b1, OP_J, 6'd0, 1'b0, S_JUMP, ST_PC, SEL_JUMP, M_PC);
    exp_ret++;
  endtask

  initial begin
    rst       = 1'b1;
    bus.en    = 1'b0;
    bus.OP    = 6'd0;
    bus.Funct = 6'd0;
    bus.Zero  = 1'b0;
    @(posedge clk);
    #1;

    // Reset held while en toggles: machine stays put, nothing strobes.
    for (int i = 0; i < 4; i++)
      step("rst hold", i[0], 6'd0, 6'd0, 1'b0, S_RESET, ST_NONE, SEL_ZERO, M_RST);
    rst = 1'b0;
    step("rst idle", 1'b0, 6'd0, 6'd0, 1'b0, S_RESET, ST_NONE, SEL_ZERO, M_RST);
    step("rst go",   1'b1, 6'd0, 6'd0, 1'b0, S_RESET, ST_NONE, SEL_ZERO, M_RST);

    run_lw();
    run_rtype("sub", FN_SUB, ULA_SUB, ST_NONE);
    run_beq(1'b1);
    run_beq(1'b0);
    run_sw_hold();
    fetch_dec("illop", OP_BAD, 6'd0, ST_ILL);
    run_addi();
    run_rtype("and", FN_AND, ULA_AND, ST_NONE);
    run_rtype("slt", FN_SLT, ULA_SLT, ST_NONE);
    run_rtype("badfn", FN_BAD, ULA_ADD, ST_ILL);
    for (int i = 0; i < 256; i++) run_j();

    // Reset landing in MEMADR abandons the lw immediately.
    fetch_dec("lw abort", OP_LW, 6'd0, ST_NONE);
    rst = 1'b1;
    exp_ret = 0;
    step("rst in memadr", 1'b1, OP_LW, 6'd0, 1'b0, S_RESET, ST_NONE, SEL_ZERO, M_RST);
    rst = 1'b0;
    step("rst after",     1'b1, OP_LW, 6'd0, 1'b0, S_RESET, ST_NONE, SEL_ZERO, M_RST);
    step("fetch after",   1'b1, OP_LW, 6'd0, 1'b0, S_FETCH, ST_FETCH, SEL_FETCH, M_FETCH);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    check("scoreboard drain", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", checks);
    $fatal(1, "watchdog expired");
  end

endmodule
